// File: rtl/mem_nr1w_be.sv
// mem_nr1w_be -- multi-read-port, single-write-port word memory with byte
// enables, optional registered read stage, optional write-to-read bypass and
// a sequential clear engine that zeroes one word per cycle after reset.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   rd_en_i        per-port read request
//   rd_addr_i      flat byte addresses, port p at [p*AW +: AW]
//   rd_dout_o      flat read data, port p at [p*WIDTH +: WIDTH]
//   rd_valid_o     per-port read data valid
//   wr_en_i        write request
//   wr_addr_i      write byte address
//   wr_din_i       write data, lane b at [8b+7:8b]
//   wr_be_i        byte enables
//   busy_o         clear engine active, no reads or writes serviced
//   dbg_state_o    clear engine state (0 = CLEAR, 1 = READY)
//   dbg_clr_idx_o  clear engine word pointer
//
// Handshake: there is no ready signal. A read or write request is accepted on
// any rising edge where its enable is high and busy_o is low; an accepted read
// always produces rd_valid_o (same cycle for latency 0, next cycle for latency
// 1). Requests made while busy_o is high are dropped, not deferred.
module mem_nr1w_be #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int RD_PORTS       = 2,
  parameter int RD_LATENCY     = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BW  = WIDTH / 8,
  localparam int OFS = $clog2(BW),
  localparam int IW  = $clog2(DEPTH),
  localparam int AW  = IW + OFS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RD_PORTS-1:0]       rd_en_i,
  input  logic [RD_PORTS*AW-1:0]    rd_addr_i,
  output logic [RD_PORTS*WIDTH-1:0] rd_dout_o,
  output logic [RD_PORTS-1:0]       rd_valid_o,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic [WIDTH-1:0]          wr_din_i,
  input  logic [BW-1:0]             wr_be_i,
  output logic                      busy_o,
  output logic                      dbg_state_o,
  output logic [IW-1:0]             dbg_clr_idx_o
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   clr_idx_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [IW-1:0]    wr_idx;
  logic             wr_fire;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  // Clear engine: walks clr_idx_q from 0 to DEPTH-1, one word per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      clr_idx_q <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_idx_q <= clr_idx_q + 1'b1;
      if (clr_idx_q == IW'(DEPTH - 1)) begin
        state_q <= S_READY;
      end
    end
  end

  assign busy_o        = (state_q == S_CLEAR);
  assign dbg_state_o   = state_q;
  assign dbg_clr_idx_o = clr_idx_q;

  assign wr_idx  = wr_addr_i[AW-1:OFS];
  assign wr_fire = wr_en_i & ~busy_o;
  assign wr_old  = mem_q[wr_idx];

  // The merged word is shared by the memory update and by every bypass path.
  always_comb begin
    wr_merged = wr_old;
    for (int b = 0; b < BW; b++) begin
      if (wr_be_i[b]) begin
        wr_merged[8*b +: 8] = wr_din_i[8*b +: 8];
      end
    end
  end

  // Array has no reset; clearing is done by the engine so it maps to RAM.
  always_ff @(posedge clk) begin
    if (busy_o) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_idx] <= wr_merged;
    end
  end

  if (OFS > 0) begin : g_wr_lo
    logic unused_wr_lo;
    assign unused_wr_lo = ^wr_addr_i[OFS-1:0];
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic             rd_fire;

    assign rd_idx  = rd_addr_i[p*AW+OFS +: IW];
    assign rd_fire = rd_en_i[p] & ~busy_o;

    always_comb begin
      rd_word = mem_q[rd_idx];
      if ((BYPASS != 0) && wr_fire && (rd_idx == wr_idx)) begin
        rd_word = wr_merged;
      end
    end

    if (OFS > 0) begin : g_rd_lo
      logic unused_rd_lo;
      assign unused_rd_lo = ^rd_addr_i[p*AW +: OFS];
    end

    if (RD_LATENCY == 0) begin : g_comb
      assign rd_dout_o[p*WIDTH +: WIDTH] = busy_o ? '0 : rd_word;
      assign rd_valid_o[p]               = rd_fire;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      // Data holds when no request is accepted; valid is a one-cycle pulse.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_fire;
          if (rd_fire) begin
            dout_q <= rd_word;
          end
        end
      end

      assign rd_dout_o[p*WIDTH +: WIDTH] = dout_q;
      assign rd_valid_o[p]               = valid_q;
    end
  end

endmodule

// File: tb/tb_mem_nr1w_be.sv
// Bench for mem_nr1w_be. Three instances share one stimulus stream:
//   dut_a: registered read, bypass on
//   dut_b: registered read, bypass off
//   dut_c: combinational read, bypass on
// All use WIDTH=32, DEPTH=16, RD_PORTS=2, CLEAR_ON_RESET=1.
module tb_mem_nr1w_be;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      rd_en   = '0;
  logic [2*AW-1:0] rd_addr = '0;
  logic            wr_en   = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [W-1:0]    wr_din  = '0;
  logic [3:0]      wr_be   = '0;

  logic [2*W-1:0] dout_a, dout_b, dout_c;
  logic [1:0]     valid_a, valid_b, valid_c;
  logic           busy_a, busy_b, busy_c;
  logic           st_a, st_b, st_c;
  logic [3:0]     idx_a, idx_b, idx_c;

  mem_nr1w_be #(.WIDTH(W), .DEPTH(D), .RD_PORTS(2), .RD_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dout_o(dout_a), .rd_valid_o(valid_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_be_i(wr_be), .busy_o(busy_a),
    .dbg_state_o(st_a), .dbg_clr_idx_o(idx_a));

  mem_nr1w_be #(.WIDTH(W), .DEPTH(D), .RD_PORTS(2), .RD_LATENCY(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dout_o(dout_b), .rd_valid_o(valid_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_be_i(wr_be), .busy_o(busy_b),
    .dbg_state_o(st_b), .dbg_clr_idx_o(idx_b));

  mem_nr1w_be #(.WIDTH(W), .DEPTH(D), .RD_PORTS(2), .RD_LATENCY(0), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .rst(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dout_o(dout_c), .rd_valid_o(valid_c),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_be_i(wr_be), .busy_o(busy_c),
    .dbg_state_o(st_c), .dbg_clr_idx_o(idx_c));

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model [D];
  logic [W-1:0] last_exp [4];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d, input logic [3:0] be);
    logic [W-1:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) last_exp[i] = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Count edges until busy drops; optionally keep a write and reads pending
  // the whole time to show they are dropped.
  task automatic wait_clear(input string tag, input bit hammer);
    int n;
    bit any_v;
    n = 0;
    any_v = 1'b0;
    if (hammer) begin
      wr_en = 1'b1; wr_addr = 6'h14; wr_din = 32'h12345678; wr_be = 4'hF;
      rd_en = 2'b11; rd_addr = {6'h14, 6'h14};
      #1;
      chk({tag, "_busyread_c"}, dout_c[31:0], 32'h0);
      chk({tag, "_busyvalid_c"}, {30'b0, valid_c}, 32'h0);
    end
    while (busy_a && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy_a && (valid_a != 0 || valid_b != 0 || valid_c != 0)) any_v = 1'b1;
      if (valid_a != 0 || valid_b != 0) any_v = 1'b1;
    end
    wr_en = 1'b0; rd_en = 2'b00; wr_be = 4'h0;
    chk({tag, "_edges"}, n, D);
    chk({tag, "_novalid"}, {31'b0, any_v}, 32'h0);
    chk({tag, "_busy_bc"}, {30'b0, busy_b, busy_c}, 32'h0);
    chk({tag, "_state_a"}, {31'b0, st_a}, 32'h1);
    model_clear();
  endtask

  // One cycle of stimulus: optional write plus reads on both ports.
  task automatic rd_cycle(input string tag, input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd, input logic [3:0] be);
    logic [W-1:0] eb [2];
    logic [W-1:0] eo [2];
    logic [AW-1:0] ad;
    logic [W-1:0] e;
    @(negedge clk);
    rd_en = en; rd_addr = {a1, a0};
    wr_en = we; wr_addr = wa; wr_din = wd; wr_be = be;
    for (int p = 0; p < 2; p++) begin
      ad = (p == 0) ? a0 : a1;
      eo[p] = model[ad[5:2]];
      eb[p] = (we && ad[5:2] == wa[5:2]) ? merge(eo[p], wd, be) : eo[p];
    end
    for (int p = 0; p < 2; p++) if (en[p]) exp_q.push_back(eb[p]);
    for (int p = 0; p < 2; p++) if (en[p]) exp_q.push_back(eo[p]);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_c_valid%0d", tag, p), {31'b0, valid_c[p]}, {31'b0, en[p]});
      if (en[p]) chk($sformatf("%s_c_dout%0d", tag, p), dout_c[p*W +: W], eb[p]);
    end
    @(posedge clk);
    if (we) model[wa[5:2]] = merge(model[wa[5:2]], wd, be);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_a_valid%0d", tag, p), {31'b0, valid_a[p]}, {31'b0, en[p]});
      if (en[p]) begin
        e = exp_q.pop_front();
        last_exp[p] = e;
      end
      chk($sformatf("%s_a_dout%0d", tag, p), dout_a[p*W +: W], last_exp[p]);
    end
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_b_valid%0d", tag, p), {31'b0, valid_b[p]}, {31'b0, en[p]});
      if (en[p]) begin
        e = exp_q.pop_front();
        last_exp[2+p] = e;
      end
      chk($sformatf("%s_b_dout%0d", tag, p), dout_b[p*W +: W], last_exp[2+p]);
    end
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [W-1:0] wd, input logic [3:0] be);
    rd_cycle("wr", 2'b00, 6'h0, 6'h0, 1'b1, wa, wd, be);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 4; i++) last_exp[i] = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {29'b0, busy_a, busy_b, busy_c}, 32'h7);
    chk("rst_valid", {26'b0, valid_a, valid_b, valid_c}, 32'h0);
    chk("rst_dout_a0", dout_a[31:0], 32'h0);
    chk("rst_dout_a1", dout_a[63:32], 32'h0);
    chk("rst_dout_b0", dout_b[31:0], 32'h0);
    chk("rst_dout_c0", dout_c[31:0], 32'h0);
    chk("rst_state_a", {27'b0, st_a, idx_a}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_clear("clr1", 1'b0);

    // Preload word 5 and confirm, then reset in the middle of a read.
    wr(6'h14, 32'hDEADBEEF, 4'hF);
    rd_cycle("preload", 2'b11, 6'h14, 6'h15, 1'b0, 6'h0, 32'h0, 4'h0);
    @(negedge clk);
    rd_en = 2'b11; rd_addr = {6'h14, 6'h14};
    @(posedge clk); #1;
    chk("midread_valid_pre", {30'b0, valid_a}, 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("midread_valid_async", {28'b0, valid_a, valid_b}, 32'h0);
    chk("midread_dout_async", dout_a[31:0], 32'h0);
    rd_en = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    wait_clear("clr2", 1'b1);
    rd_cycle("cleared5", 2'b11, 6'h14, 6'h17, 1'b0, 6'h0, 32'h0, 4'h0);

    // Byte enables, low address bits ignored.
    wr(6'h20, 32'h11223344, 4'hF);
    wr(6'h20, 32'hAABBCCDD, 4'b0101);
    rd_cycle("be", 2'b11, 6'h20, 6'h23, 1'b0, 6'h0, 32'h0, 4'h0);
    wr(6'h21, 32'h99999999, 4'h0);
    rd_cycle("be_noop", 2'b01, 6'h22, 6'h0, 1'b0, 6'h0, 32'h0, 4'h0);

    // Bypass: same-cycle write and read to word 3.
    rd_cycle("bypass", 2'b01, 6'h0C, 6'h00, 1'b1, 6'h0C, 32'hFFFFFFFF, 4'b0011);
    chk("bypass_a_const", dout_a[31:0], 32'h0000FFFF);
    chk("bypass_b_const", dout_b[31:0], 32'h00000000);
    rd_cycle("after_bypass", 2'b11, 6'h0C, 6'h0D, 1'b0, 6'h0, 32'h0, 4'h0);
    chk("after_bypass_b_const", dout_b[31:0], 32'h0000FFFF);

    // Dual port: different words, then same word.
    wr(6'h04, 32'h1, 4'hF);
    wr(6'h08, 32'h2, 4'hF);
    rd_cycle("dual", 2'b11, 6'h04, 6'h08, 1'b0, 6'h0, 32'h0, 4'h0);
    chk("dual_const", dout_a, {32'h2, 32'h1});
    rd_cycle("same", 2'b11, 6'h04, 6'h04, 1'b0, 6'h0, 32'h0, 4'h0);

    // Combinational read path and hold of registered data when idle.
    wr(6'h10, 32'hCAFE0001, 4'hF);
    rd_cycle("lat0", 2'b01, 6'h10, 6'h00, 1'b0, 6'h0, 32'h0, 4'h0);
    rd_cycle("lat0_off", 2'b00, 6'h10, 6'h00, 1'b0, 6'h0, 32'h0, 4'h0);
    chk("hold_a_const", dout_a[31:0], 32'hCAFE0001);

    // Randomised mix, bypass cases included by reusing the write address.
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 63));
      rd_cycle("rnd", 2'($urandom_range(0, 3)),
               ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, 63)),
               AW'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset during a clear restarts the engine.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_clear("clr3", 1'b0);
    for (int i = 0; i < D / 2; i++) begin
      rd_cycle("allzero", 2'b11, AW'(8 * i), AW'(8 * i + 4), 1'b0, 6'h0, 32'h0, 4'h0);
    end

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_nr1w_be.md
# mem_nr1w_be

Parametrised multi-read-port, single-write-port word memory with byte-enable writes, an optional registered read stage, and optional write-to-read bypass. It replaces the single-port-pair register-array memory. It serves as data memory (byte/half stores) and as a shared instruction/data array behind the pipeline's fetch and load/store stages. Reset clearing is done by a sequential clear engine, one word per cycle, instead of a bulk clear.

## Interface
- WIDTH, 32: word width in bits; must be a multiple of 8. BW = WIDTH/8 byte lanes, OFS = $clog2(BW).
- DEPTH, 256: number of words; must be a power of two, at least 2. AW = $clog2(DEPTH)+OFS (byte address width).
- RD_PORTS, 2: number of independent read ports, at least 1.
- RD_LATENCY, 1: 0 = combinational read; 1 = registered read.
- BYPASS, 1: 1 = a same-cycle write to the same word is visible on the read; 0 = read returns the old contents.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset via the clear engine; 0 = contents untouched, no busy period.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_en  in  RD_PORTS  per-port read request.
- rd_addr  in  RD_PORTS*AW  flat byte addresses; port p uses bits [p*AW +: AW].
- rd_dout  out  RD_PORTS*WIDTH  flat read data; port p uses bits [p*WIDTH +: WIDTH].
- rd_valid  out  RD_PORTS  per-port read data valid.
- wr_en  in  1  write request.
- wr_addr  in  AW  write byte address.
- wr_din  in  WIDTH  write data; lane b is bits [8b+7:8b].
- wr_be  in  BW  byte enables.
- busy  out  1  clear engine active; reads and writes are not serviced.

## Operation
- Word index = addr[AW-1:OFS]. The low OFS address bits are ignored on every port. No misalignment error is raised; the requester pre-shifts data and enables.
- Write: when wr_en=1 and busy=0, at the clock edge each lane b with wr_be[b]=1 is replaced. Lanes with wr_be[b]=0 keep their value. wr_be=0 is a legal no-op.
- Read, RD_LATENCY=0: rd_dout[p] = the word at rd_addr[p] combinationally. rd_valid[p] = rd_en[p] & ~busy. rd_dout[p] is 0 while busy.
- Read, RD_LATENCY=1: on an edge with rd_en[p]=1 and busy=0, rd_dout[p] is loaded and rd_valid[p]=1 in the next cycle. If rd_en[p]=0, rd_valid[p]=0 and rd_dout[p] holds its last value.
- Bypass (same word index, wr_en=1, same cycle):
  - BYPASS=1: the read returns the merged word (new lanes where wr_be=1, old lanes elsewhere).
  - BYPASS=0: the read returns the pre-write word.
  - Applies independently to each port and to both latencies.
- Multiple ports may read the same word in the same cycle; all return identical data.
- Clear engine FSM (CLEAR_ON_RESET=1), states CLEAR and READY:
  - rst low: state=CLEAR, clr_idx=0, busy=1.
  - CLEAR: each edge writes 0 to word clr_idx and increments clr_idx. On the edge that writes DEPTH-1, the state goes to READY.
  - READY: busy=0. The FSM stays in READY until the next reset.
  - External wr_en and rd_en are ignored in CLEAR (no write, no valid).
- CLEAR_ON_RESET=0: the FSM resets directly to READY and busy=0. Contents are unaffected by reset.
- Reset mid-clear: the engine restarts at clr_idx=0.
- Reset mid-read: rd_valid drops immediately (asynchronously).

## Timing
- Reset values: rd_dout=0 and rd_valid=0 on all ports. busy=1 if CLEAR_ON_RESET, else 0.
- Clear duration: exactly DEPTH rising edges after rst deasserts. busy is 0 from the cycle after the last clear write.
- Write-to-read latency: a write at edge N is visible to an ordinary (non-bypass) read presented in cycle N+1.
- RD_LATENCY=1: request in cycle N, data and valid in cycle N+1. Back-to-back requests give one result per cycle per port.
- No stalls or backpressure once READY; every accepted request completes.

## Test plan
- Reset/clear (DEPTH=16, CLEAR_ON_RESET=1): preload word 5 = 0xDEADBEEF, pulse rst → busy=1 for exactly 16 edges; then a read of 0x14 returns 0x00000000 and a write issued while busy is dropped.
- Byte enables: write 0x11223344 to 0x20 with be=1111, then 0xAABBCCDD with be=0101 → a read of 0x20 (and 0x23, low bits ignored) returns 0x11BB33DD.
- Bypass, RD_LATENCY=1: word 3 = 0x0; same cycle, write 0xFFFFFFFF to 0x0C with be=0011 and read 0x0C on port 0 → next cycle rd_dout0=0x0000FFFF, rd_valid0=1 with BYPASS=1, and 0x00000000 with BYPASS=0.
- Dual port: port 0 reads 0x04 and port 1 reads 0x08 on the same cycle, holding 0x1 and 0x2 → 0x1 and 0x2 returned together. Both ports reading 0x04 → both return 0x1.
- Reset mid-clear: deassert rst, reassert after 5 edges, release → busy lasts a full DEPTH edges from the second release; all words read 0.
- RD_LATENCY=0: rd_en=1, rd_addr=0x10 with word 4 = 0xCAFE0001 → same-cycle rd_dout=0xCAFE0001, rd_valid=1. With rd_en=0, rd_valid=0.
